// File: rtl/tow_referee.sv
// Tug-of-war referee: start countdown, rope position tracking, win/foul hold.
// Optional PLAY idle-timeout (draw) enabled by defining TOW_TIMEOUT_EN.
module tow_referee #(
  parameter int NPOS          = 7,
  parameter int COUNT_TICKS   = 3,
  parameter int HOLD_TICKS    = 5,
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            slowen,
  input  logic            start,
  input  logic            pbl,
  input  logic            pbr,
  output logic [NPOS-1:0] leds,
  output logic [3:0]      count,
  output logic            winl,
  output logic            winr,
  output logic            foul,
  output logic            draw
);

  localparam int PW = $clog2(NPOS);
  localparam logic [PW-1:0] CENTRE = PW'((NPOS - 1) / 2);
  localparam logic [PW-1:0] TOP    = PW'(NPOS - 1);
  localparam logic [PW-1:0] ONE    = PW'(1);
  localparam logic [PW-1:0] ZERO   = '0;

  typedef enum logic [2:0] {IDLE, ARM, PLAY, WIN, FOUL} state_t;

  state_t        state;
  logic [PW-1:0] pos;
  logic [3:0]    hold;
  logic          pbl_q, pbr_q;
  logic          pl, pr;
  logic [PW-1:0] pos_up, pos_dn;

  assign pl     = pbl & ~pbl_q;
  assign pr     = pbr & ~pbr_q;
  assign pos_up = pos + ONE;
  assign pos_dn = pos - ONE;

  function automatic logic [NPOS-1:0] onehot(input logic [PW-1:0] p);
    logic [NPOS-1:0] v;
    v = {{(NPOS-1){1'b0}}, 1'b1};
    return v << p;
  endfunction

`ifdef TOW_TIMEOUT_EN
  logic [3:0] idle;
`else
  assign draw = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pos   <= CENTRE;
      leds  <= onehot(CENTRE);
      count <= 4'd0;
      winl  <= 1'b0;
      winr  <= 1'b0;
      foul  <= 1'b0;
      hold  <= 4'd0;
      pbl_q <= 1'b0;
      pbr_q <= 1'b0;
`ifdef TOW_TIMEOUT_EN
      draw  <= 1'b0;
      idle  <= 4'd0;
`endif
    end else begin
      pbl_q <= pbl;
      pbr_q <= pbr;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ARM;
            count <= 4'(COUNT_TICKS);
          end
        end
        ARM: begin
          // a press beats a coincident countdown tick
          if (pl | pr) begin
            state <= FOUL;
            count <= 4'd0;
            foul  <= 1'b1;
            winl  <= pr & ~pl;
            winr  <= pl & ~pr;
            hold  <= 4'd0;
          end else if (slowen) begin
            if (count == 4'd1) begin
              state <= PLAY;
              count <= 4'd0;
`ifdef TOW_TIMEOUT_EN
              idle  <= 4'd0;
`endif
            end else begin
              count <= count - 4'd1;
            end
          end
        end
        PLAY: begin
          if (pl & ~pr) begin
            pos  <= pos_up;
            leds <= onehot(pos_up);
`ifdef TOW_TIMEOUT_EN
            idle <= 4'd0;
`endif
            if (pos_up == TOP) begin
              state <= WIN;
              winl  <= 1'b1;
              hold  <= 4'd0;
            end
          end else if (pr & ~pl) begin
            pos  <= pos_dn;
            leds <= onehot(pos_dn);
`ifdef TOW_TIMEOUT_EN
            idle <= 4'd0;
`endif
            if (pos_dn == ZERO) begin
              state <= WIN;
              winr  <= 1'b1;
              hold  <= 4'd0;
            end
          end
`ifdef TOW_TIMEOUT_EN
          else if (slowen) begin
            if (idle == 4'(TIMEOUT_TICKS - 1)) begin
              state <= WIN;
              draw  <= 1'b1;
              hold  <= 4'd0;
            end else begin
              idle <= idle + 4'd1;
            end
          end
`endif
        end
        WIN, FOUL: begin
          if (slowen) begin
            if (hold == 4'(HOLD_TICKS - 1)) begin
              state <= IDLE;
              pos   <= CENTRE;
              leds  <= onehot(CENTRE);
              winl  <= 1'b0;
              winr  <= 1'b0;
              foul  <= 1'b0;
              hold  <= 4'd0;
`ifdef TOW_TIMEOUT_EN
              draw  <= 1'b0;
`endif
            end else begin
              hold <= hold + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tow_referee.sv
// Directed plus randomized bench for tow_referee against a rule-level game model.
module tb_tow_referee;
  localparam int NPOS = 7, CT = 3, HT = 5, TT = 10;

  logic clk = 1'b0;
  logic rst, slowen, start, pbl, pbr;
  logic [NPOS-1:0] leds;
  logic [3:0] count;
  logic winl, winr, foul, draw;

  int vectors = 0, miscompares = 0;

  // model: game phase as plain integers (0 waiting, 1 countdown, 2 playing, 3 showing result)
  int m_phase, m_pos, m_cnt, m_hold, m_idle;
  bit m_wl, m_wr, m_f, m_d, m_ql, m_qr;

  tow_referee #(.NPOS(NPOS), .COUNT_TICKS(CT), .HOLD_TICKS(HT), .TIMEOUT_TICKS(TT)) dut (
    .clk(clk), .rst(rst), .slowen(slowen), .start(start), .pbl(pbl), .pbr(pbr),
    .leds(leds), .count(count), .winl(winl), .winr(winr), .foul(foul), .draw(draw)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit pl, pr;
    int d;
    pl = pbl && !m_ql;
    pr = pbr && !m_qr;
    m_ql = pbl;
    m_qr = pbr;
    if (rst) begin
      m_phase = 0; m_pos = (NPOS - 1) / 2; m_cnt = 0; m_hold = 0; m_idle = 0;
      m_wl = 0; m_wr = 0; m_f = 0; m_d = 0; m_ql = 0; m_qr = 0;
      return;
    end
    case (m_phase)
      0: if (start) begin m_phase = 1; m_cnt = CT; end
      1: begin
        if (pl || pr) begin
          m_phase = 3; m_cnt = 0; m_hold = 0; m_f = 1;
          m_wl = pr && !pl; m_wr = pl && !pr;
        end else if (slowen) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin m_phase = 2; m_idle = 0; end
        end
      end
      2: begin
        d = (pl ? 1 : 0) - (pr ? 1 : 0);
        if (d != 0) begin
          m_pos = m_pos + d; m_idle = 0;
          if (m_pos == NPOS - 1) begin m_phase = 3; m_hold = 0; m_wl = 1; end
          if (m_pos == 0) begin m_phase = 3; m_hold = 0; m_wr = 1; end
        end
`ifdef TOW_TIMEOUT_EN
        else if (slowen) begin
          m_idle = m_idle + 1;
          if (m_idle == TT) begin m_phase = 3; m_hold = 0; m_d = 1; end
        end
`endif
      end
      default: if (slowen) begin
        m_hold = m_hold + 1;
        if (m_hold == HT) begin
          m_phase = 0; m_pos = (NPOS - 1) / 2; m_hold = 0;
          m_wl = 0; m_wr = 0; m_f = 0; m_d = 0;
        end
      end
    endcase
  endtask

  task automatic check(input string tag);
    logic [NPOS+7:0] got, exp;
    logic [NPOS-1:0] el;
    el = '0;
    el[m_pos] = 1'b1;
    exp = {el, 4'(m_cnt), m_wl, m_wr, m_f, m_d};
    got = {leds, count, winl, winr, foul, draw};
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0t leds/count/wl/wr/foul/draw got=%b required=%b", tag, $time, got, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit l, input bit rr, input bit t, input string tag);
    rst = r; start = s; pbl = l; pbr = rr; slowen = t;
    @(posedge clk);
    model_step();
    #1;
    check(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, 0, 1, tag);
      cyc(0, 0, 0, 0, 0, tag);
    end
  endtask

  initial begin
    bit l, r;
    rst = 1; start = 0; pbl = 0; pbr = 0; slowen = 0;
    m_ql = 0; m_qr = 0; m_phase = 0; m_pos = (NPOS - 1) / 2;
    m_cnt = 0; m_hold = 0; m_idle = 0; m_wl = 0; m_wr = 0; m_f = 0; m_d = 0;

    // reset and countdown
    cyc(1, 0, 0, 0, 0, "reset");
    cyc(1, 0, 0, 0, 0, "reset");
    cyc(0, 0, 0, 0, 1, "idle_tick");
    cyc(0, 1, 0, 0, 0, "start");
    cyc(0, 0, 0, 0, 0, "arm");
    ticks(CT, "countdown");

    // left win with three presses, then hold and return
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, 0, "press_left");
      cyc(0, 0, 0, 0, 0, "release_left");
    end
    cyc(0, 1, 1, 1, 0, "win_ignores_inputs");
    cyc(0, 0, 0, 0, 0, "win_hold");
    ticks(HT, "win_hold");

    // false start by right player while count=2
    cyc(0, 1, 0, 0, 0, "start2");
    ticks(1, "arm_tick");
    cyc(0, 0, 0, 1, 1, "false_start_right");
    cyc(0, 0, 0, 0, 0, "foul_hold");
    ticks(HT, "foul_hold");

    // both-at-once false start
    cyc(0, 1, 0, 0, 0, "start3");
    cyc(0, 0, 1, 1, 0, "false_start_both");
    cyc(0, 0, 0, 0, 0, "foul_both");
    ticks(HT, "foul_both_hold");

    // simultaneous and held buttons in PLAY, then reset mid-game
    cyc(0, 1, 0, 0, 0, "start4");
    ticks(CT, "countdown4");
    cyc(0, 0, 1, 1, 0, "both_no_move");
    cyc(0, 0, 0, 0, 0, "both_release");
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, i[0], "held_left");
    cyc(0, 0, 0, 0, 0, "held_release");
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0, "press_right");
      cyc(0, 0, 0, 0, 0, "release_right");
    end
    cyc(1, 0, 1, 0, 1, "reset_midgame");
    cyc(0, 0, 0, 0, 0, "after_reset");

`ifdef TOW_TIMEOUT_EN
    cyc(0, 1, 0, 0, 0, "start_to");
    ticks(CT, "countdown_to");
    ticks(TT, "timeout");
    ticks(HT, "draw_hold");
    cyc(0, 1, 0, 0, 0, "start_to2");
    ticks(CT, "countdown_to2");
    ticks(TT - 1, "pre_timeout");
    cyc(0, 0, 1, 0, 1, "press_on_timeout");
    cyc(0, 0, 0, 0, 0, "no_draw");
`endif

    // randomized play
    l = 0; r = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) l = !l;
      if ($urandom_range(0, 3) == 0) r = !r;
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, l, r,
          $urandom_range(0, 3) == 0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
